// File: rtl/vx_kmu_cta_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// VX_kmu_pkg
//   Shared types for the KMU CTA dispatcher and the KMU request bus:
//     - build-time defaults for XLEN / NUM_THREADS / NUM_WARPS
//     - kmu_state_e    : dispatcher FSM states
//     - kmu_cmd_t      : latched launch command
//     - kmu_req_data_t : one per-CTA request on VX_kmu_bus_if
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package VX_kmu_pkg;

  localparam int KMU_XLEN        = `XLEN;
  localparam int KMU_NUM_THREADS = `NUM_THREADS;
  localparam int KMU_NUM_WARPS   = `NUM_WARPS;
  // Wide enough to hold the value NUM_WARPS itself (a full CTA).
  localparam int KMU_NW_BITS     = $clog2(KMU_NUM_WARPS + 1);

  typedef enum logic [1:0] {
    KMU_IDLE     = 2'd0,
    KMU_SETUP    = 2'd1,
    KMU_DISPATCH = 2'd2,
    KMU_DONE     = 2'd3
  } kmu_state_e;

  typedef struct packed {
    logic [KMU_XLEN-1:0] start_pc;
    logic [KMU_XLEN-1:0] param;
    logic [31:0]         grid_x;
    logic [31:0]         grid_y;
    logic [31:0]         grid_z;
    logic [31:0]         block_size;
  } kmu_cmd_t;

  typedef struct packed {
    logic [KMU_NW_BITS-1:0]     num_warps;
    logic [KMU_XLEN-1:0]        start_pc;
    logic [KMU_XLEN-1:0]        param;
    logic [31:0]                x;
    logic [31:0]                y;
    logic [31:0]                z;
    logic [31:0]                cta_id;
    logic [KMU_NUM_THREADS-1:0] remain_mask;
  } kmu_req_data_t;

endpackage

// File: rtl/VX_kmu_bus_if.sv
// -----------------------------------------------------------------------------
// VX_kmu_bus_if
//   Valid/ready request channel carrying one kmu_req_data_t per CTA.
//   master: drives req_valid/req_data, samples req_ready
//   slave : samples req_valid/req_data, drives req_ready
// -----------------------------------------------------------------------------
interface VX_kmu_bus_if;
  import VX_kmu_pkg::*;

  logic          req_valid;
  kmu_req_data_t req_data;
  logic          req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/vx_kmu_cta_dispatch_grid_iter.sv
// -----------------------------------------------------------------------------
// VX_kmu_grid_iter
//   3-D x-fastest wrap counter with a linear id.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     clear               : zero the counters and latch grid bounds
//     step                : advance one position (ignored while clear)
//     grid_x/y/z          : grid bounds, sampled only on clear
//     x, y, z             : current coordinates
//     id                  : linear position, wraps modulo 2^32
//     last                : current position is the final one of the grid
// -----------------------------------------------------------------------------
module VX_kmu_grid_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step,
  input  logic [31:0] grid_x,
  input  logic [31:0] grid_y,
  input  logic [31:0] grid_z,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] z,
  output logic [31:0] id,
  output logic        last
);

  // Bounds are held as (dim - 1) so the wrap tests are plain equality.
  logic [31:0] max_x_q, max_y_q, max_z_q;
  logic [31:0] x_q, y_q, z_q, id_q;
  logic [31:0] x_d, y_d, z_d, id_d;
  logic        x_wrap, y_wrap, z_wrap;

  assign x_wrap = (x_q == max_x_q);
  assign y_wrap = (y_q == max_y_q);
  assign z_wrap = (z_q == max_z_q);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    z_d  = z_q;
    id_d = id_q;
    if (clear) begin
      x_d  = '0;
      y_d  = '0;
      z_d  = '0;
      id_d = '0;
    end else if (step) begin
      id_d = id_q + 32'd1;
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          z_d = z_q + 32'd1;
        end else begin
          y_d = y_q + 32'd1;
        end
      end else begin
        x_d = x_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      id_q    <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      max_z_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      z_q  <= z_d;
      id_q <= id_d;
      if (clear) begin
        // A zero bound underflows here, but the dispatcher never steps
        // through a grid with a zero dimension.
        max_x_q <= grid_x - 32'd1;
        max_y_q <= grid_y - 32'd1;
        max_z_q <= grid_z - 32'd1;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;
  assign id   = id_q;
  assign last = x_wrap && y_wrap && z_wrap;

endmodule

// File: rtl/vx_kmu_cta_dispatch.sv
// -----------------------------------------------------------------------------
// vx_kmu_cta_dispatch
//   Accepts one kernel-launch command, walks the CTA grid x-fastest and emits
//   one KMU request per CTA, with warp count and last-warp thread mask.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     start_valid / start_ready  : launch command handshake (ready == idle)
//     start_pc, param            : kernel entry PC and argument pointer
//     grid_x/y/z                 : grid dimensions in CTAs
//     block_size                 : threads per CTA
//     kmu_bus_if                 : per-CTA request channel (master side)
//     busy                       : command in progress
//     done                       : one-cycle pulse at command completion
//     error                      : one-cycle pulse when a CTA needs more
//                                  than NUM_WARPS warps (command dropped)
//   NUM_THREADS must be a power of two >= 2 and match the package width
//   used for remain_mask; NUM_WARPS must match the package width used for
//   num_warps.
// -----------------------------------------------------------------------------
module vx_kmu_cta_dispatch
  import VX_kmu_pkg::*;
#(
  parameter int NUM_THREADS = KMU_NUM_THREADS,
  parameter int NUM_WARPS   = KMU_NUM_WARPS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [KMU_XLEN-1:0] start_pc,
  input  logic [KMU_XLEN-1:0] param,
  input  logic [31:0]         grid_x,
  input  logic [31:0]         grid_y,
  input  logic [31:0]         grid_z,
  input  logic [31:0]         block_size,
  VX_kmu_bus_if.master        kmu_bus_if,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int LOG2_NT = $clog2(NUM_THREADS);

  kmu_state_e                 state_q, state_d;
  kmu_cmd_t                   cmd_q;
  logic [KMU_NW_BITS-1:0]     num_warps_q;
  logic [NUM_THREADS-1:0]     mask_q;

  // SETUP-cycle arithmetic, all from the latched command.
  logic [32:0]                warps_full;
  logic [LOG2_NT-1:0]         rem;
  logic [NUM_THREADS-1:0]     mask_calc;
  logic                       cmd_zero;
  logic                       cmd_over;

  logic                       req_valid;
  logic                       iter_clear;
  logic                       iter_step;
  logic [31:0]                cta_x, cta_y, cta_z, cta_id;
  logic                       cta_last;

  // Ceil-divide by the warp width; 33 bits keeps the carry when block_size
  // is close to 2^32 so such commands are still seen as oversized.
  assign warps_full = ({1'b0, cmd_q.block_size} + 33'(NUM_THREADS - 1)) >> LOG2_NT;
  assign rem        = cmd_q.block_size[LOG2_NT-1:0];
  assign cmd_zero   = (cmd_q.grid_x == '0) || (cmd_q.grid_y == '0) ||
                      (cmd_q.grid_z == '0) || (cmd_q.block_size == '0);
  assign cmd_over   = (warps_full > 33'(NUM_WARPS));

  // Last-warp mask: lanes below rem are active; rem == 0 means a full warp.
  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_mask
      assign mask_calc[gi] = (rem == '0) || (LOG2_NT'(gi) < rem);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= KMU_IDLE;
      cmd_q       <= '0;
      num_warps_q <= '0;
      mask_q      <= '0;
    end else begin
      state_q <= state_d;
      // Fields are captured once; later input changes are not followed.
      if (state_q == KMU_IDLE && start_valid) begin
        cmd_q <= '{start_pc:   start_pc,
                   param:      param,
                   grid_x:     grid_x,
                   grid_y:     grid_y,
                   grid_z:     grid_z,
                   block_size: block_size};
      end
      if (state_q == KMU_SETUP) begin
        // Truncation only matters for oversized commands, which never
        // reach DISPATCH.
        num_warps_q <= KMU_NW_BITS'(warps_full);
        mask_q      <= mask_calc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    req_valid   = 1'b0;
    case (state_q)
      KMU_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_d = KMU_SETUP;
      end
      KMU_SETUP: begin
        if (cmd_zero) begin
          state_d = KMU_DONE;
        end else if (cmd_over) begin
          error   = 1'b1;
          state_d = KMU_DONE;
        end else begin
          state_d = KMU_DISPATCH;
        end
      end
      KMU_DISPATCH: begin
        req_valid = 1'b1;
        if (kmu_bus_if.req_ready && cta_last) state_d = KMU_DONE;
      end
      KMU_DONE: begin
        done    = 1'b1;
        state_d = KMU_IDLE;
      end
      default: state_d = KMU_IDLE;
    endcase
  end

  assign iter_clear = (state_q == KMU_SETUP);
  assign iter_step  = req_valid && kmu_bus_if.req_ready;

  VX_kmu_grid_iter u_grid_iter (
    .clk    (clk),
    .reset  (reset),
    .clear  (iter_clear),
    .step   (iter_step),
    .grid_x (cmd_q.grid_x),
    .grid_y (cmd_q.grid_y),
    .grid_z (cmd_q.grid_z),
    .x      (cta_x),
    .y      (cta_y),
    .z      (cta_z),
    .id     (cta_id),
    .last   (cta_last)
  );

  // Request payload comes only from registers, so it is stable while
  // the request waits on req_ready.
  assign kmu_bus_if.req_valid = req_valid;
  assign kmu_bus_if.req_data  = '{num_warps:   num_warps_q,
                                  start_pc:    cmd_q.start_pc,
                                  param:       cmd_q.param,
                                  x:           cta_x,
                                  y:           cta_y,
                                  z:           cta_z,
                                  cta_id:      cta_id,
                                  remain_mask: mask_q};

endmodule
